// File: rtl/dlfloat_cmp_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dlfloat_cmp_stream_if : operand/result stream bundle for the DLfloat      |
// | compare/select unit. Revision: 1.0                                        |
// +--------------------------------------------------------------------------+
interface dlfloat_cmp_stream_if #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 9,
  parameter int CNT_W = 8
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a1;
  logic [W-1:0]     b1;
  logic [2:0]       sel;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     c_out;
  logic [CNT_W-1:0] out_count;
  logic [4:0]       exceptions;

  // master feeds operands and consumes results; slave is the compare unit
  modport master (
    output in_valid, a1, b1, sel, in_last, out_ready,
    input  in_ready, out_valid, c_out, out_count, exceptions
  );

  modport slave (
    input  in_valid, a1, b1, sel, in_last, out_ready,
    output in_ready, out_valid, c_out, out_count, exceptions
  );
endinterface
`default_nettype wire

// File: rtl/dlfloat_cmp_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dlfloat_cmp_stream : handshaked DLfloat compare/select with streaming     |
// | MIN/MAX reductions over in_last-delimited packets. Revision: 1.0          |
// +--------------------------------------------------------------------------+
module dlfloat_cmp_stream #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 9,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dlfloat_cmp_stream_if.slave  bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] C_OP_MIN  = 3'b001;
  localparam logic [2:0] C_OP_MAX  = 3'b010;
  localparam logic [2:0] C_OP_EQ   = 3'b011;
  localparam logic [2:0] C_OP_LT   = 3'b100;
  localparam logic [2:0] C_OP_LE   = 3'b101;

  localparam logic [W-1:0]     C_NAN     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     C_ONES    = {W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // NaN is the single all-ones exponent/mantissa code, either sign
  function automatic logic f_is_nan(input logic [W-1:0] x);
    return &x[W-2:0];
  endfunction

  function automatic logic f_is_zero(input logic [W-1:0] x);
    return ~|x[W-2:0];
  endfunction

  function automatic logic f_lt(input logic [W-1:0] x, input logic [W-1:0] y);
    logic r;
    if (f_is_zero(x) && f_is_zero(y))
      r = 1'b0;
    else if (x[W-1] != y[W-1])
      r = x[W-1];
    else if (x[W-1])
      r = (x[W-2:0] > y[W-2:0]);
    else
      r = (x[W-2:0] < y[W-2:0]);
    return r;
  endfunction

  function automatic logic f_eq(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x == y) || (f_is_zero(x) && f_is_zero(y));
  endfunction

  // Ties keep x; a +0/-0 pair resolves by sign so MIN yields -0 and MAX +0
  function automatic logic [W-1:0] f_pick(input logic is_max,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0] r;
    if (f_is_zero(x) && f_is_zero(y))
      r = {(is_max ? (x[W-1] & y[W-1]) : (x[W-1] | y[W-1])), {(W-1){1'b0}}};
    else if (is_max)
      r = f_lt(x, y) ? y : x;
    else
      r = f_lt(y, x) ? y : x;
    return r;
  endfunction

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_red;
  logic             w_beat_nan;
  logic [W-1:0]     w_elem_res;
  logic             w_elem_inv;
  logic             w_red_max;
  logic [W-1:0]     w_pair;
  logic [W-1:0]     w_fold;
  logic [CNT_W-1:0] w_red_cnt;
  logic             w_red_sticky;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sticky;
  logic             w_sticky_nxt;
  logic             r_op_max;
  logic             w_op_max_nxt;

  logic             w_emit;
  logic [W-1:0]     w_res;
  logic [CNT_W-1:0] w_res_cnt;
  logic             w_res_inv;

  logic             r_out_valid;
  logic [W-1:0]     r_c_out;
  logic [CNT_W-1:0] r_out_count;
  logic             r_invalid;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_red   = bus.sel[2] & bus.sel[1];
  assign w_beat_nan = f_is_nan(bus.a1) | f_is_nan(bus.b1);

  always_comb begin
    w_elem_res = '0;
    w_elem_inv = 1'b0;
    case (bus.sel)
      C_OP_MIN, C_OP_MAX: begin
        w_elem_inv = w_beat_nan;
        w_elem_res = w_beat_nan ? C_NAN
                                : f_pick(bus.sel == C_OP_MAX, bus.a1, bus.b1);
      end
      C_OP_EQ: begin
        w_elem_inv = w_beat_nan;
        w_elem_res = (!w_beat_nan && f_eq(bus.a1, bus.b1)) ? C_ONES : '0;
      end
      C_OP_LT: begin
        w_elem_inv = w_beat_nan;
        w_elem_res = (!w_beat_nan && f_lt(bus.a1, bus.b1)) ? C_ONES : '0;
      end
      C_OP_LE: begin
        w_elem_inv = w_beat_nan;
        w_elem_res = (!w_beat_nan && (f_lt(bus.a1, bus.b1) || f_eq(bus.a1, bus.b1)))
                     ? C_ONES : '0;
      end
      default: ;
    endcase
  end

  // Inside a packet the latched op wins over whichever reduce sel is presented
  assign w_red_max    = (r_state == ST_ACC) ? r_op_max : bus.sel[0];
  assign w_pair       = f_pick(w_red_max, bus.a1, bus.b1);
  assign w_fold       = (r_state == ST_ACC) ? f_pick(w_red_max, r_acc, w_pair) : w_pair;
  assign w_red_cnt    = (r_state == ST_IDLE)   ? C_CNT_ONE :
                        (r_cnt == C_CNT_MAX)   ? r_cnt     : r_cnt + C_CNT_ONE;
  assign w_red_sticky = w_beat_nan | ((r_state == ST_ACC) & r_sticky);

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_sticky_nxt = r_sticky;
    w_op_max_nxt = r_op_max;
    w_emit       = 1'b0;
    w_res        = w_elem_res;
    w_res_cnt    = C_CNT_ONE;
    w_res_inv    = w_elem_inv;
    if (w_accept) begin
      if (w_is_red) begin
        w_acc_nxt    = w_fold;
        w_cnt_nxt    = w_red_cnt;
        w_sticky_nxt = w_red_sticky;
        w_op_max_nxt = w_red_max;
        if (bus.in_last) begin
          w_emit      = 1'b1;
          w_res       = w_red_sticky ? C_NAN : w_fold;
          w_res_cnt   = w_red_cnt;
          w_res_inv   = w_red_sticky;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACC;
        end
      end else begin
        w_emit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_op_max <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sticky <= w_sticky_nxt;
      r_op_max <= w_op_max_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_c_out     <= '0;
      r_out_count <= '0;
      r_invalid   <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_c_out     <= w_res;
      r_out_count <= w_res_cnt;
      r_invalid   <= w_res_inv;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.c_out      = r_c_out;
  assign bus.out_count  = r_out_count;
  assign bus.exceptions = {r_invalid, 4'b0000};

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_cmp_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dlfloat_cmp_stream : directed and random checks of dlfloat_cmp_stream  |
// | against a value-level reference model. Revision: 1.0                      |
// +--------------------------------------------------------------------------+
module tb_dlfloat_cmp_stream;
  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int CNT_W = 8;

  localparam logic [2:0] C_OP_RSV  = 3'b000;
  localparam logic [2:0] C_OP_MIN  = 3'b001;
  localparam logic [2:0] C_OP_MAX  = 3'b010;
  localparam logic [2:0] C_OP_EQ   = 3'b011;
  localparam logic [2:0] C_OP_LT   = 3'b100;
  localparam logic [2:0] C_OP_LE   = 3'b101;
  localparam logic [2:0] C_OP_RMIN = 3'b110;
  localparam logic [2:0] C_OP_RMAX = 3'b111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dlfloat_cmp_stream_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) bus ();

  dlfloat_cmp_stream #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (real-valued ordering) ----------------
  typedef struct {
    logic [15:0] c;
    logic [7:0]  n;
    logic [4:0]  e;
  } res_t;

  res_t        exp_q[$];
  bit          pkt_open = 1'b0;
  bit          pkt_max  = 1'b0;
  bit          pkt_nan  = 1'b0;
  int          pkt_beats = 0;
  logic [15:0] pkt_vals[$];

  function automatic bit is_nan(input logic [15:0] x);
    return x[14:0] == 15'h7FFF;
  endfunction

  function automatic real to_real(input logic [15:0] x);
    int  e;
    real m;
    real mag;
    e = int'(x[14:9]);
    m = real'(x[8:0]);
    if (e == 0) mag = (m / 512.0) * $pow(2.0, -30.0);
    else        mag = (1.0 + m / 512.0) * $pow(2.0, real'(e - 31));
    return x[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] better(input bit want_max, input logic [15:0] a,
                                         input logic [15:0] b);
    real va;
    real vb;
    va = to_real(a);
    vb = to_real(b);
    if (va == vb && va == 0.0)
      return {(want_max ? (a[15] & b[15]) : (a[15] | b[15])), 15'h0000};
    if (want_max ? (vb > va) : (vb < va)) return b;
    return a;
  endfunction

  function automatic res_t elem(input logic [2:0] s, input logic [15:0] a,
                                input logic [15:0] b);
    res_t r;
    real  va;
    real  vb;
    r.c = 16'h0000; r.n = 8'd1; r.e = 5'b00000;
    va = to_real(a);
    vb = to_real(b);
    if (s != C_OP_RSV && (is_nan(a) || is_nan(b))) begin
      r.e = 5'b10000;
      r.c = (s == C_OP_MIN || s == C_OP_MAX) ? 16'h7FFF : 16'h0000;
      return r;
    end
    case (s)
      C_OP_MIN: r.c = better(1'b0, a, b);
      C_OP_MAX: r.c = better(1'b1, a, b);
      C_OP_EQ:  r.c = (va == vb) ? 16'hFFFF : 16'h0000;
      C_OP_LT:  r.c = (va <  vb) ? 16'hFFFF : 16'h0000;
      C_OP_LE:  r.c = (va <= vb) ? 16'hFFFF : 16'h0000;
      default:  r.c = 16'h0000;
    endcase
    return r;
  endfunction

  task automatic model_accept(input logic [15:0] a, input logic [15:0] b,
                              input logic [2:0] s, input logic last);
    res_t        r;
    logic [15:0] best;
    if (s == C_OP_RMIN || s == C_OP_RMAX) begin
      if (!pkt_open) begin
        pkt_open  = 1'b1;
        pkt_max   = (s == C_OP_RMAX);
        pkt_nan   = 1'b0;
        pkt_beats = 0;
        pkt_vals.delete();
      end
      pkt_vals.push_back(a);
      pkt_vals.push_back(b);
      pkt_nan = pkt_nan | is_nan(a) | is_nan(b);
      pkt_beats++;
      if (last) begin
        best = pkt_vals[0];
        foreach (pkt_vals[i]) best = better(pkt_max, best, pkt_vals[i]);
        r.c = pkt_nan ? 16'h7FFF : best;
        r.n = (pkt_beats > 255) ? 8'd255 : 8'(pkt_beats);
        r.e = pkt_nan ? 5'b10000 : 5'b00000;
        exp_q.push_back(r);
        pkt_open = 1'b0;
      end
    end else begin
      exp_q.push_back(elem(s, a, b));
    end
  endtask

  // ---------------- scoreboard, sampled on the falling edge ----------------
  bit   mon_ev;
  res_t mon_r;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ev = (exp_q.size() != 0);
      check("out_valid", 32'(bus.out_valid), 32'(mon_ev));
      check("in_ready", 32'(bus.in_ready), 32'(!mon_ev || bus.out_ready));
      if (mon_ev && bus.out_valid) begin
        mon_r = exp_q[0];
        check("c_out", 32'(bus.c_out), 32'(mon_r.c));
        check("out_count", 32'(bus.out_count), 32'(mon_r.n));
        check("exceptions", 32'(bus.exceptions), 32'(mon_r.e));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      if (bus.in_valid && (!mon_ev || bus.out_ready))
        model_accept(bus.a1, bus.b1, bus.sel, bus.in_last);
    end
  end

  // 0: random backpressure, 1: always ready, 2: stalled
  int ready_mode = 1;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver helpers (enter and leave at posedge+1) ----------------
  task automatic put_beat(input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] s, input logic last);
    bus.a1 = a; bus.b1 = b; bus.sel = s; bus.in_last = last; bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] s, input logic last);
    put_beat(a, b, s, last);
    wait_accept();
  endtask

  task automatic expect_out(input string tag, input logic [15:0] c,
                            input logic [7:0] n, input logic [4:0] e);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_c"}, 32'(bus.c_out), 32'(c));
    check({tag, "_cnt"}, 32'(bus.out_count), 32'(n));
    check({tag, "_exc"}, 32'(bus.exceptions), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_none(input string tag);
    @(negedge clk);
    check({tag, "_novalid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    pkt_open = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_exceptions", 32'(bus.exceptions), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 9))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      4:       return 16'h3E00;
      5:       return 16'hBE00;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          wait_n;
    bus.in_valid = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.sel = '0; bus.in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // element ops
    send(16'h3E00, 16'h4000, C_OP_MIN, 1'b0); expect_out("min", 16'h3E00, 8'd1, 5'b00000);
    send(16'h3E00, 16'h4000, C_OP_MAX, 1'b0); expect_out("max", 16'h4000, 8'd1, 5'b00000);
    send(16'hBE00, 16'h3E00, C_OP_LE, 1'b0);  expect_out("le", 16'hFFFF, 8'd1, 5'b00000);
    send(16'h0000, 16'h8000, C_OP_EQ, 1'b0);  expect_out("eq_zero", 16'hFFFF, 8'd1, 5'b00000);
    send(16'h0000, 16'h8000, C_OP_MIN, 1'b0); expect_out("min_zero", 16'h8000, 8'd1, 5'b00000);
    send(16'h8000, 16'h0000, C_OP_MAX, 1'b0); expect_out("max_zero", 16'h0000, 8'd1, 5'b00000);
    send(16'h7FFF, 16'h3E00, C_OP_LT, 1'b0);  expect_out("lt_nan", 16'h0000, 8'd1, 5'b10000);
    send(16'h7FFF, 16'h3E00, C_OP_MAX, 1'b0); expect_out("max_nan", 16'h7FFF, 8'd1, 5'b10000);
    send(16'h7FFF, 16'h3E00, C_OP_RSV, 1'b0); expect_out("rsv", 16'h0000, 8'd1, 5'b00000);

    // RMAX packet
    send(16'h3E00, 16'hBE00, C_OP_RMAX, 1'b0); expect_none("rmax_b1");
    send(16'h4000, 16'h3E00, C_OP_RMAX, 1'b0); expect_none("rmax_b2");
    send(16'h3E00, 16'h3E00, C_OP_RMAX, 1'b1); expect_out("rmax", 16'h4000, 8'd3, 5'b00000);

    // backpressure: a stalled result blocks the next beat
    ready_mode = 2;
    send(16'h3E00, 16'h4000, C_OP_MIN, 1'b0);
    put_beat(16'h4000, 16'h4200, C_OP_MAX, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold", 32'(bus.c_out), 32'h3E00);
      @(posedge clk);
      #1;
    end
    ready_mode = 1;
    wait_accept();
    expect_out("bp_second", 16'h4200, 8'd1, 5'b00000);

    // element op interleaved into an RMIN packet
    send(16'h4000, 16'h4200, C_OP_RMIN, 1'b0);
    send(16'h3E00, 16'h3E00, C_OP_EQ, 1'b0);   expect_out("ilv_eq", 16'hFFFF, 8'd1, 5'b00000);
    send(16'h3C00, 16'h4400, C_OP_RMIN, 1'b1); expect_out("ilv_rmin", 16'h3C00, 8'd2, 5'b00000);

    // reset mid-packet, then a fresh packet
    send(16'h4000, 16'h3E00, C_OP_RMAX, 1'b0);
    do_reset();
    send(16'h3E00, 16'h4000, C_OP_RMAX, 1'b1); expect_out("post_rst", 16'h4000, 8'd1, 5'b00000);

    // randomized traffic under random backpressure
    ready_mode = 0;
    for (int i = 0; i < 400; i++) begin
      ra = rand_op();
      rb = ($urandom_range(0, 4) == 0) ? ra : rand_op();
      send(ra, rb, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 1;
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 20) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
